// File: rtl/lr35902_lcd_fb.sv
// lr35902_lcd_fb: packs the PPU 2bpp pixel stream into a 160x144 linear
// framebuffer (40 bytes/line) through a small byte FIFO and a ready/valid
// write port.
// Ports: clk, reset (async, active-low); PPU side disp_on, hsync, vsync,
// px_out, px; memory side fb_adr, fb_dout, fb_write, fb_ready; status
// frame_done, fill_busy, sticky err_ovf/err_long/err_short, err_clr.
// Option: define LR35902_LCD_FB_BLANK_FILL_EN to zero-fill the framebuffer
// whenever the LCD is switched off.
module lr35902_lcd_fb #(
    parameter int          DEPTH   = 4,
    parameter logic [12:0] FB_BASE = 13'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_on,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        px_out,
    input  logic [1:0]  px,
    output logic [12:0] fb_adr,
    output logic [7:0]  fb_dout,
    output logic        fb_write,
    input  logic        fb_ready,
    output logic        frame_done,
    output logic        fill_busy,
    output logic        err_ovf,
    output logic        err_long,
    output logic        err_short,
    input  logic        err_clr
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [12:0] LAST_OFS = 13'd5759;
    localparam logic [12:0] LAST_ADR = FB_BASE + LAST_OFS;

    typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_FILL} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [12:0] r_line_base;
    logic [5:0]  r_pack;
    logic        r_frame_drop;
    logic        r_frame_done;
    logic        r_err_ovf;
    logic        r_err_long;
    logic        r_err_short;

    // FIFO entry: {last-of-clean-frame, address, data}
    logic [21:0] r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic [21:0] w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_ovf;

    logic [7:0]  w_x_nxt;
    logic [7:0]  w_y_nxt;
    logic [12:0] w_base_nxt;
    logic [5:0]  w_pack_nxt;
    logic [7:0]  w_byte;
    logic [12:0] w_adr;
    logic        w_push;
    logic [21:0] w_push_ent;
    logic        w_set_short;
    logic        w_set_long;
    logic        w_frame_clr;
    logic        w_flush;

`ifdef LR35902_LCD_FB_BLANK_FILL_EN
    logic        r_disp_q;
    logic [12:0] r_fill_cnt;
`endif

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[AW] != r_rd[AW]) &&
                       (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_head    = r_mem[r_rd[AW-1:0]];
    assign w_pop     = !w_empty && fb_ready;
    // a full FIFO drops the byte even if a pop happens on the same clk
    assign w_push_ok = w_push && !w_full;
    assign w_ovf     = w_push && w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_WAIT;
            r_x          <= '0;
            r_y          <= '0;
            r_line_base  <= FB_BASE;
            r_pack       <= '0;
            r_frame_drop <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_line_base  <= w_base_nxt;
            r_pack       <= w_pack_nxt;
            if (w_frame_clr)
                r_frame_drop <= 1'b0;
            else if (w_ovf)
                r_frame_drop <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_base_nxt  = r_line_base;
        w_pack_nxt  = r_pack;
        w_byte      = '0;
        w_adr       = '0;
        w_push      = 1'b0;
        w_push_ent  = '0;
        w_set_short = 1'b0;
        w_set_long  = 1'b0;
        w_frame_clr = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (vsync && disp_on) begin
                    w_state_nxt = S_ACTIVE;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_base_nxt  = FB_BASE;
                    w_pack_nxt  = '0;
                    w_frame_clr = 1'b1;
                end
`ifdef LR35902_LCD_FB_BLANK_FILL_EN
                else if (r_disp_q && !disp_on) begin
                    w_state_nxt = S_FILL;
                    w_flush     = 1'b1;
                end
`endif
            end
            S_ACTIVE: begin
                if (!disp_on) begin
`ifdef LR35902_LCD_FB_BLANK_FILL_EN
                    w_state_nxt = S_FILL;
                    w_flush     = 1'b1;
`else
                    w_state_nxt = S_WAIT;
`endif
                end else begin
                    // line boundary is applied before a same-clk pixel
                    if (hsync) begin
                        if (r_y < 8'd144 && r_x != 8'd0 && r_x < 8'd160)
                            w_set_short = 1'b1;
                        w_x_nxt    = '0;
                        w_pack_nxt = '0;
                        if (vsync) begin
                            w_y_nxt     = '0;
                            w_base_nxt  = FB_BASE;
                            w_frame_clr = 1'b1;
                        end else if (r_y < 8'd144) begin
                            w_y_nxt    = r_y + 8'd1;
                            w_base_nxt = r_line_base + 13'd40;
                        end
                    end
                    if (px_out) begin
                        if (w_y_nxt < 8'd144 && w_x_nxt < 8'd160) begin
                            w_byte     = {w_pack_nxt, px};
                            w_pack_nxt = w_byte[5:0];
                            if (w_x_nxt[1:0] == 2'd3) begin
                                w_adr      = w_base_nxt +
                                             {7'd0, w_x_nxt[7:2]};
                                w_push     = 1'b1;
                                w_push_ent = {(w_adr == LAST_ADR) &&
                                              !r_frame_drop,
                                              w_adr, w_byte};
                            end
                            w_x_nxt = w_x_nxt + 8'd1;
                        end else if (w_y_nxt < 8'd144) begin
                            w_set_long = 1'b1;
                        end
                    end
                end
            end
            S_FILL: begin
`ifdef LR35902_LCD_FB_BLANK_FILL_EN
                if (fb_ready && r_fill_cnt == LAST_OFS)
                    w_state_nxt = S_WAIT;
`else
                w_state_nxt = S_WAIT;
`endif
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (w_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push_ok)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr[AW-1:0]] <= w_push_ent;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_done <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_long   <= 1'b0;
            r_err_short  <= 1'b0;
        end else begin
            r_frame_done <= w_pop && w_head[21] && !w_flush;
            r_err_ovf    <= (r_err_ovf & ~err_clr) | w_ovf;
            r_err_long   <= (r_err_long & ~err_clr) | w_set_long;
            r_err_short  <= (r_err_short & ~err_clr) | w_set_short;
        end
    end

`ifdef LR35902_LCD_FB_BLANK_FILL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp_q   <= 1'b0;
            r_fill_cnt <= '0;
        end else begin
            r_disp_q <= disp_on;
            if (w_flush)
                r_fill_cnt <= '0;
            else if (r_state == S_FILL && fb_ready)
                r_fill_cnt <= r_fill_cnt + 13'd1;
        end
    end
`endif

    always_comb begin
        fb_write = !w_empty;
        fb_adr   = w_empty ? 13'd0 : w_head[20:8];
        fb_dout  = w_empty ? 8'd0 : w_head[7:0];
`ifdef LR35902_LCD_FB_BLANK_FILL_EN
        if (r_state == S_FILL) begin
            fb_write = 1'b1;
            fb_adr   = FB_BASE + r_fill_cnt;
            fb_dout  = 8'd0;
        end
`endif
    end

`ifdef LR35902_LCD_FB_BLANK_FILL_EN
    assign fill_busy = (r_state == S_FILL);
`else
    assign fill_busy = 1'b0;
`endif

    assign frame_done = r_frame_done;
    assign err_ovf    = r_err_ovf;
    assign err_long   = r_err_long;
    assign err_short  = r_err_short;

endmodule

// File: tb/tb_lr35902_lcd_fb.sv
// tb_lr35902_lcd_fb: directed stimulus for lr35902_lcd_fb with a frame-level
// reference model compared every cycle plus hand-computed expectations.
module tb_lr35902_lcd_fb;
    localparam int          DEPTH   = 4;
    localparam logic [12:0] FB_BASE = 13'h0000;
`ifdef LR35902_LCD_FB_BLANK_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        disp_on = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        px_out = 1'b0;
    logic [1:0]  px = 2'd0;
    logic        fb_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [12:0] fb_adr;
    logic [7:0]  fb_dout;
    logic        fb_write;
    logic        frame_done;
    logic        fill_busy;
    logic        err_ovf;
    logic        err_long;
    logic        err_short;

    lr35902_lcd_fb #(.DEPTH(DEPTH), .FB_BASE(FB_BASE)) dut (
        .clk(clk), .reset(reset), .disp_on(disp_on), .hsync(hsync),
        .vsync(vsync), .px_out(px_out), .px(px), .fb_adr(fb_adr),
        .fb_dout(fb_dout), .fb_write(fb_write), .fb_ready(fb_ready),
        .frame_done(frame_done), .fill_busy(fill_busy), .err_ovf(err_ovf),
        .err_long(err_long), .err_short(err_short), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int log_adr[$];
    int log_dat[$];
    int log_cyc[$];
    int fd_cnt = 0;
    int fd_cyc = 0;
    int fill_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d",
                     nm, act, exp, cyc);
        end
    endtask

    // reference model: frame position in lines/pixels, pending writes queue
    typedef struct { int adr; int dat; bit last; } ent_t;
    ent_t mq[$];
    int   grp[$];
    int   m_state = 0;
    int   m_x = 0;
    int   m_y = 0;
    int   m_fcnt = 0;
    bit   m_drop = 0;
    bit   m_fd = 0;
    bit   m_ovf = 0;
    bit   m_long = 0;
    bit   m_short = 0;
    bit   m_dprev = 0;
    bit   p_stall = 0;
    logic [12:0] p_adr;
    logic [7:0]  p_dat;

    bit exp_w, acc, set_o, set_l, set_s;
    int qs, e_adr, e_dat, b, a;

    task automatic start_fill();
        m_state = 2;
        m_fcnt = 0;
        mq.delete();
        grp.delete();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("reset_outs", {fb_write, frame_done, fill_busy, err_ovf,
                err_long, err_short, fb_adr, fb_dout}, 32'd0);
            mq.delete(); grp.delete();
            m_state = 0; m_x = 0; m_y = 0; m_fcnt = 0; m_drop = 0;
            m_fd = 0; m_ovf = 0; m_long = 0; m_short = 0; m_dprev = 0;
            p_stall = 0;
        end else begin
            exp_w = (mq.size() != 0) || (m_state == 2);
            chk("fb_write", fb_write, exp_w);
            if (exp_w) begin
                if (m_state == 2) begin
                    e_adr = FB_BASE + m_fcnt; e_dat = 0;
                end else begin
                    e_adr = mq[0].adr; e_dat = mq[0].dat;
                end
                chk("fb_adr", fb_adr, e_adr);
                chk("fb_dout", fb_dout, e_dat);
            end
            if (p_stall)
                chk("stall_hold", {fb_write, fb_adr, fb_dout},
                    {1'b1, p_adr, p_dat});
            chk("frame_done", frame_done, m_fd);
            chk("err_flags", {err_ovf, err_long, err_short},
                {m_ovf, m_long, m_short});
            chk("fill_busy", fill_busy, m_state == 2);
            p_stall = fb_write && !fb_ready;
            p_adr = fb_adr;
            p_dat = fb_dout;
            if (fb_write && fb_ready) begin
                log_adr.push_back(fb_adr);
                log_dat.push_back(fb_dout);
                log_cyc.push_back(cyc);
            end
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (fill_busy) fill_cyc++;

            acc = exp_w && fb_ready;
            qs = mq.size();
            m_fd = acc && (m_state != 2) && mq[0].last;
            if (acc && m_state != 2) void'(mq.pop_front());
            set_o = 0; set_l = 0; set_s = 0;
            if (m_state == 0) begin
                if (vsync && disp_on) begin
                    m_state = 1; m_x = 0; m_y = 0; m_drop = 0; grp.delete();
                end else if (FILL_EN && m_dprev && !disp_on) begin
                    start_fill();
                end
            end else if (m_state == 1) begin
                if (!disp_on) begin
                    if (FILL_EN) start_fill();
                    else m_state = 0;
                end else begin
                    if (hsync) begin
                        if (m_y < 144 && m_x > 0 && m_x < 160) set_s = 1;
                        m_x = 0; grp.delete();
                        if (vsync) begin m_y = 0; m_drop = 0; end
                        else if (m_y < 144) m_y++;
                    end
                    if (px_out) begin
                        if (m_y < 144 && m_x < 160) begin
                            grp.push_back(int'(px));
                            m_x++;
                            if (grp.size() == 4) begin
                                b = grp[0] * 64 + grp[1] * 16 + grp[2] * 4 + grp[3];
                                a = FB_BASE + m_y * 40 + (m_x - 1) / 4;
                                grp.delete();
                                if (qs >= DEPTH) begin
                                    set_o = 1; m_drop = 1;
                                end else begin
                                    mq.push_back('{a, b,
                                        (a == FB_BASE + 5759) && !m_drop});
                                end
                            end
                        end else if (m_y < 144) begin
                            set_l = 1;
                        end
                    end
                end
            end else begin
                if (acc) begin
                    m_fcnt++;
                    if (m_fcnt == 5760) m_state = 0;
                end
            end
            m_ovf = (m_ovf && !err_clr) || set_o;
            m_long = (m_long && !err_clr) || set_l;
            m_short = (m_short && !err_clr) || set_s;
            m_dprev = disp_on;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pcol(input int i, input int mode);
        case (mode)
            0: return 2'(3 - (i % 4));
            1: return 2'((i + i / 4) % 4);
            default: return 2'((i * 3 + mode) % 4);
        endcase
    endfunction

    task automatic send_line(input int n, input bit vs, input int mode);
        hsync = 1'b1; vsync = vs; px_out = 1'b0;
        tick();
        hsync = 1'b0; vsync = 1'b0;
        for (int i = 0; i < n; i++) begin
            px_out = 1'b1; px = pcol(i, mode);
            tick();
        end
        px_out = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain();
        int k;
        k = 0;
        repeat (3) tick();
        while (fb_write && k < 200) begin tick(); k++; end
        chk("drain_timeout", fb_write, 1'b0);
        repeat (2) tick();
    endtask

    function automatic int count_adr(input int from, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = from; i < log_adr.size(); i++)
            if (log_adr[i] >= lo && log_adr[i] <= hi) n++;
        return n;
    endfunction

    int mk;
    int fd0;
    int fc0;
    int nz;
    int exp5[5] = '{0, 1, 2, 3, 5};

    initial begin
        repeat (3) tick();
        chk("reset_state", {fb_write, err_ovf, err_long, err_short}, 4'd0);
        reset = 1'b1;
        disp_on = 1'b1;
        fb_ready = 1'b1;
        tick();

        // one E4 line
        mk = log_adr.size();
        send_line(160, 1'b1, 0);
        drain();
        chk("t1_count", log_adr.size() - mk, 40);
        for (int i = 0; i < 40; i++) begin
            chk("t1_adr", log_adr[mk + i], i);
            chk("t1_dat", log_dat[mk + i], 8'hE4);
        end
        chk("t1_errs", {err_ovf, err_long, err_short}, 3'd0);

        // full frame then blank lines
        mk = log_adr.size();
        fd0 = fd_cnt;
        for (int l = 0; l < 144; l++)
            send_line(160, l == 0, 1 + (l % 3));
        for (int l = 0; l < 10; l++)
            send_line(0, 1'b0, 0);
        drain();
        chk("t2_count", log_adr.size() - mk, 5760);
        chk("t2_last_adr", log_adr[log_adr.size() - 1], 5759);
        chk("t2_fd_once", fd_cnt - fd0, 1);
        chk("t2_fd_lat", fd_cyc - log_cyc[log_cyc.size() - 1], 1);

        // stall for 20 clks at 1 px/clk
        mk = log_adr.size();
        fd0 = fd_cnt;
        hsync = 1'b1; vsync = 1'b1;
        tick();
        hsync = 1'b0; vsync = 1'b0;
        for (int i = 0; i < 160; i++) begin
            fb_ready = (i >= 20);
            px_out = 1'b1; px = pcol(i, 0);
            tick();
        end
        px_out = 1'b0;
        fb_ready = 1'b1;
        drain();
        chk("t3_count", log_adr.size() - mk, 39);
        chk("t3_no_adr4", count_adr(mk, 4, 4), 0);
        for (int i = 0; i < 5; i++)
            chk("t3_order", log_adr[mk + i], exp5[i]);
        chk("t3_ovf", err_ovf, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk("t3_clr", err_ovf, 1'b0);

        // long line, then short line
        mk = log_adr.size();
        send_line(160, 1'b1, 0);
        send_line(162, 1'b0, 1);
        send_line(6, 1'b0, 2);
        send_line(3, 1'b0, 0);
        drain();
        chk("t4_line1", count_adr(mk, 40, 79), 40);
        chk("t4_adr80", count_adr(mk, 80, 80), 1);
        chk("t4_adr81", count_adr(mk, 81, 200), 0);
        chk("t4_flags", {err_long, err_short}, 2'b11);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk("t4_clr", {err_ovf, err_long, err_short}, 3'd0);
        hsync = 1'b1; err_clr = 1'b1;
        tick();
        hsync = 1'b0; err_clr = 1'b0;
        tick();
        chk("t4_set_wins", {err_long, err_short}, 2'b01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();

        // pixels before vsync, then async reset mid-line
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        mk = log_adr.size();
        send_line(20, 1'b0, 0);
        drain();
        chk("t5_no_vsync", log_adr.size() - mk, 0);
        hsync = 1'b1; vsync = 1'b1;
        tick();
        hsync = 1'b0; vsync = 1'b0;
        fb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            px_out = 1'b1; px = pcol(i, 1);
            tick();
        end
        px_out = 1'b0;
        chk("t5_pending", fb_write, 1'b1);
        reset = 1'b0;
        #1;
        chk("t5_async", fb_write, 1'b0);
        tick();
        reset = 1'b1;
        fb_ready = 1'b1;
        tick();

        // LCD switched off mid-frame
        send_line(40, 1'b1, 1);
        drain();
        mk = log_adr.size();
        fc0 = fill_cyc;
        disp_on = 1'b0;
        for (int k = 0; k < 50; k++) begin
            px_out = 1'b1; px = pcol(k, 0);
            hsync = (k == 10) || (k == 20);
            vsync = (k == 20);
            if (k == 30) disp_on = 1'b1;
            tick();
        end
        px_out = 1'b0; hsync = 1'b0; vsync = 1'b0;
        for (int k = 0; k < 6000 && fill_busy; k++) tick();
        drain();
`ifdef LR35902_LCD_FB_BLANK_FILL_EN
        chk("t6_fill_clks", fill_cyc - fc0, 5760);
        chk("t6_fill_cnt", log_adr.size() - mk, 5760);
        chk("t6_first", log_adr[mk], 0);
        chk("t6_last", log_adr[log_adr.size() - 1], 5759);
        nz = 0;
        for (int i = mk; i < log_dat.size(); i++)
            if (log_dat[i] != 0) nz++;
        chk("t6_zero", nz, 0);
`else
        chk("t6_untouched", log_adr.size() - mk, 0);
        chk("t6_no_busy", fill_cyc - fc0, 0);
`endif
        mk = log_adr.size();
        send_line(160, 1'b1, 0);
        drain();
        chk("t6_restart_cnt", log_adr.size() - mk, 40);
        chk("t6_restart_adr", log_adr[mk], 0);
        chk("t6_restart_dat", log_dat[mk], 8'hE4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
